mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the core's data-memory bus, in parallel with the main memory array and LED/RGB registers.
- Consumes the store port (write_mem, funct3, write_address, write_data) and answers loads on the read port.
- Buffers bytes in a small FIFO and serialises them 8N1 (or 8E1) on a single TX pin, giving the RV32I core a console output.

---
 rtl/mmio_uart_tx_if.sv | 23 ++
 rtl/mmio_uart_tx.sv | 200 ++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the console UART: store port, registered load port,
// serial TX pin and the idle interrupt.
interface mmio_uart_tx_if;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] read_address;
    logic [31:0] read_data;
    logic        hit;
    logic        tx;
    logic        irq;

    modport master (
        output write_mem, funct3, write_address, write_data, read_address,
        input  read_data, hit, tx, irq
    );

    modport slave (
        input  write_mem, funct3, write_address, write_data, read_address,
        output read_data, hit, tx, irq
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 serialiser on the data bus.
// Define UART_PARITY_EN for 8E1 framing (even parity bit, advertised in STATUS bit9).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FFF0,
    parameter int unsigned CLK_HZ     = 12000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus
);
    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned BW  = $clog2(DIV + 1);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(DIV - 1);
    localparam logic [BW-1:0] BAUD_ONE = BW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // IDLE: wait/pop | START: tx low | DATA: lsb first | PARITY: even | STOP: tx high
`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    localparam logic FEAT_BIT = 1'b1;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
    localparam logic FEAT_BIT = 1'b0;
`endif

    state_t          state_q;
    logic [BW-1:0]   baud_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic            tx_q;
`ifdef UART_PARITY_EN
    logic            parity_q;
`endif

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            irq_q;
    logic            hit_q;
    logic [31:0]     rd_data_q;

    logic in_win_w, in_win_r, push_req, clr_req;
    logic full, empty, busy, pop, push, ovf_set;
    logic [31:0] status;

    assign in_win_w = bus.write_address[31:4] == BASE_ADDR[31:4];
    assign in_win_r = bus.read_address[31:4] == BASE_ADDR[31:4];
    assign push_req = bus.write_mem && in_win_w && (bus.write_address[3:2] == 2'd0);
    assign clr_req  = bus.write_mem && in_win_w && (bus.write_address[3:2] == 2'd1)
                      && bus.write_data[3];

    assign full    = count_q == FULL_CNT;
    assign empty   = count_q == '0;
    assign busy    = state_q != S_IDLE;
    assign pop     = (state_q == S_IDLE) && !empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push    = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;

    assign status = {22'd0, FEAT_BIT, 5'(count_q), ovf_q, empty, full, busy};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (clr_req) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.write_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b1;
            hit_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            irq_q     <= empty && !busy;
            hit_q     <= in_win_r;
            rd_data_q <= (in_win_r && (bus.read_address[3:2] == 2'd1)) ? status : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q  <= mem_q[rd_ptr_q];
`ifdef UART_PARITY_EN
                        parity_q <= ^mem_q[rd_ptr_q];
`endif
                        baud_q   <= BIT_LAST;
                        tx_q     <= 1'b0;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (baud_q == '0) begin
                        baud_q  <= BIT_LAST;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q - BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (baud_q == '0) begin
                        baud_q <= BIT_LAST;
                        if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            idx_q   <= idx_q + 3'd1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - BAUD_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (baud_q == '0) begin
                        baud_q  <= BIT_LAST;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q - BAUD_ONE;
                    end
                end
`endif
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (baud_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q - BAUD_ONE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx        = tx_q;
    assign bus.irq       = irq_q;
    assign bus.hit       = hit_q;
    assign bus.read_data = rd_data_q;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.funct3, bus.write_data[31:8],
                               bus.write_address[1:0], bus.read_address[1:0]};
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame timing, FIFO fill/overflow,
// push-during-pop and reset mid-frame.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'hFFFF_FFF0;
    localparam int          DIV  = 104;
`ifdef UART_PARITY_EN
    localparam int          FRAME_BITS = 11;
    localparam logic [31:0] FEAT       = 32'h200;
    localparam int          LAST_RUN   = 2 * DIV;
`else
    localparam int          FRAME_BITS = 10;
    localparam logic [31:0] FEAT       = 32'h0;
    localparam int          LAST_RUN   = DIV;
`endif
    localparam int FRAME = FRAME_BITS * DIV;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    mmio_uart_tx_if bus_if ();

    mmio_uart_tx #(
        .BASE_ADDR (BASE),
        .CLK_HZ    (12000000),
        .BAUD      (115200),
        .FIFO_DEPTH(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        bus_if.write_mem     = 1'b1;
        bus_if.write_address = addr;
        bus_if.write_data    = data;
        bus_if.funct3        = f3;
        step();
        bus_if.write_mem     = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, output logic [31:0] data, output logic h);
        bus_if.read_address = addr;
        step();
        data = bus_if.read_data;
        h    = bus_if.hit;
    endtask

    // Line receiver: samples mid-bit after each falling edge seen while enabled.
    logic       mon_en = 1'b0;
    logic [7:0] rx_q[$];

    initial begin : rx_mon
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        b    = '0;
        forever begin
            step();
            if (mon_en && prev && !bus_if.tx) begin
                repeat (DIV / 2) step();
                check_eq("rx_start", 32'(bus_if.tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) step();
                    b[i] = bus_if.tx;
                end
`ifdef UART_PARITY_EN
                repeat (DIV) step();
                check_eq("rx_parity", 32'(bus_if.tx), 32'(^b));
`endif
                repeat (DIV) step();
                check_eq("rx_stop", 32'(bus_if.tx), 32'd1);
                rx_q.push_back(b);
            end
            prev = bus_if.tx;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] d;
        logic        h;
        logic        cur;
        logic        stop_ok;
        int          len;
        int          t0;
        int          lows;

        bus_if.write_mem     = 1'b0;
        bus_if.funct3        = 3'b000;
        bus_if.write_address = '0;
        bus_if.write_data    = '0;
        bus_if.read_address  = '0;

        reset = 1'b1;
        repeat (3) step();
        check_eq("rst_tx", 32'(bus_if.tx), 32'd1);
        check_eq("rst_irq", 32'(bus_if.irq), 32'd1);
        check_eq("rst_hit", 32'(bus_if.hit), 32'd0);
        check_eq("rst_rdata", bus_if.read_data, 32'd0);
        reset = 1'b0;

        load(BASE + 32'h4, d, h);
        check_eq("status_reset", d, 32'h4 | FEAT);
        check_eq("status_hit", 32'(h), 32'd1);
        load(BASE + 32'h8, d, h);
        check_eq("rsvd_rdata", d, 32'd0);
        check_eq("rsvd_hit", 32'(h), 32'd1);
        load(BASE, d, h);
        check_eq("txdata_reads0", d, 32'd0);
        load(32'h0000_1004, d, h);
        check_eq("outside_rdata", d, 32'd0);
        check_eq("outside_hit", 32'(h), 32'd0);

        store(BASE + 32'h8, 32'h41, 3'b000);
        store(32'hFFFF_FFE0, 32'h42, 3'b000);
        repeat (3) step();
        load(BASE + 32'h5, d, h);
        check_eq("no_push_status", d, 32'h4 | FEAT);
        check_eq("no_push_tx", 32'(bus_if.tx), 32'd1);

        // Single byte 0x55: every bit toggles, so run lengths give the bit timing.
        mon_en = 1'b1;
        store(BASE, 32'hFFFF_FF55, 3'b000);
        len = 0;
        while (bus_if.tx && len < 4) begin
            step();
            len++;
        end
        check_eq("fall_within_2", 32'(len <= 2 && !bus_if.tx), 32'd1);
        cur = 1'b0;
        for (int r = 0; r < 9; r++) begin
            len = 0;
            while (bus_if.tx == cur && len < 400) begin
                step();
                len++;
            end
            check_eq($sformatf("run%0d", r), 32'(len), 32'((r == 8) ? LAST_RUN : DIV));
            cur = ~cur;
        end
        len     = 0;
        stop_ok = 1'b1;
        while (!bus_if.irq && len < 400) begin
            stop_ok &= bus_if.tx;
            step();
            len++;
        end
        check_eq("stop_high", 32'(stop_ok), 32'd1);
        check_eq("irq_after_stop", 32'(len >= DIV && len <= DIV + 2), 32'd1);
        check_eq("rx55_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check_eq("rx55_byte", 32'(rx_q[0]), 32'h55);
        rx_q.delete();

        // Nine back-to-back stores: first pops straight away, eight fill the FIFO.
        t0 = 0;
        for (int k = 1; k <= 9; k++) begin
            store(BASE, {24'h123456, 8'(k)}, 3'(k % 3));
            if (k == 1) t0 = cyc + 1;
            if (k == 2) check_eq("pop_immediate", 32'(bus_if.tx), 32'd0);
        end
        load(BASE + 32'h4, d, h);
        check_eq("status_full", d, 32'h83 | FEAT);
        store(BASE + 32'h2, 32'h0A, 3'b010);
        load(BASE + 32'h4, d, h);
        check_eq("status_ovf", d, 32'h8B | FEAT);
        store(BASE + 32'h4, 32'hFFFF_FFF7, 3'b010);
        load(BASE + 32'h4, d, h);
        check_eq("ovf_kept_bit3_0", d, 32'h8B | FEAT);
        store(BASE + 32'h4, 32'h8, 3'b010);
        load(BASE + 32'h4, d, h);
        check_eq("ovf_cleared", d, 32'h83 | FEAT);

        // Push on the exact edge the FSM pops from the full FIFO.
        while (cyc < t0 + FRAME) step();
        check_eq("idle_gap_tx", 32'(bus_if.tx), 32'd1);
        store(BASE, 32'h0B, 3'b000);
        check_eq("b2b_start", 32'(bus_if.tx), 32'd0);
        load(BASE + 32'h4, d, h);
        check_eq("push_pop_full", d, 32'h83 | FEAT);

        len = 0;
        while (rx_q.size() < 10 && len < 11 * FRAME + 2000) begin
            step();
            len++;
        end
        check_eq("rx_total", 32'(rx_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < rx_q.size(); i++)
            check_eq($sformatf("order%0d", i), 32'(rx_q[i]), (i < 9) ? 32'(i + 1) : 32'h0B);
        len = 0;
        while (!bus_if.irq && len < 300) begin
            step();
            len++;
        end
        check_eq("irq_drained", 32'(bus_if.irq), 32'd1);
        load(BASE + 32'h4, d, h);
        check_eq("status_drained", d, 32'h4 | FEAT);

        // Reset during data bit 3 of 0xA5 with three bytes still queued.
        mon_en = 1'b0;
        store(BASE, 32'hA5, 3'b000);
        t0 = cyc + 1;
        store(BASE, 32'h11, 3'b000);
        store(BASE, 32'h22, 3'b000);
        store(BASE, 32'h33, 3'b000);
        while (cyc < t0 + 3 * DIV + DIV / 2) step();
        check_eq("a5_bit2", 32'(bus_if.tx), 32'd1);
        while (cyc < t0 + 4 * DIV + DIV / 2) step();
        check_eq("a5_bit3", 32'(bus_if.tx), 32'd0);
        reset = 1'b1;
        step();
        check_eq("rst_mid_tx", 32'(bus_if.tx), 32'd1);
        check_eq("rst_mid_irq", 32'(bus_if.irq), 32'd1);
        reset = 1'b0;
        load(BASE + 32'h4, d, h);
        check_eq("rst_mid_status", d, 32'h4 | FEAT);
        lows = 0;
        repeat (2000) begin
            step();
            if (!bus_if.tx) lows++;
        end
        check_eq("no_start_after_rst", 32'(lows), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
